// File: rtl/risc_pkg.sv
// Shared constants for the VeriRISC-class accumulator CPU: opcode encodings
// and the eight-phase instruction cycle.
package risc_pkg;

  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  typedef enum logic [2:0] {
    PHASE_INST_ADDR  = 3'd0,
    PHASE_INST_FETCH = 3'd1,
    PHASE_INST_LOAD  = 3'd2,
    PHASE_IDLE       = 3'd3,
    PHASE_OP_ADDR    = 3'd4,
    PHASE_OP_FETCH   = 3'd5,
    PHASE_ALU_OP     = 3'd6,
    PHASE_STORE      = 3'd7
  } phase_e;

endpackage

// File: rtl/risc_cpu_if.sv
// Memory bus between the CPU core (master) and the unified instruction/data
// memory (slave).
interface risc_cpu_if #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
);

  logic [AWIDTH-1:0] addr;
  logic [DWIDTH-1:0] wdata;
  logic [DWIDTH-1:0] rdata;
  logic              we;

  modport master (output addr, output wdata, output we, input rdata);
  modport slave  (input addr, input wdata, input we, output rdata);

endinterface

// File: rtl/risc_memory.sv
// Unified 2**AWIDTH x DWIDTH instruction/data memory: combinational read,
// clocked write. Preloaded hierarchically through ram[].
module risc_memory #(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input logic       clk,
  risc_cpu_if.slave mem_bus
);

  logic [DWIDTH-1:0] ram [0:2**AWIDTH-1];

  assign mem_bus.rdata = ram[mem_bus.addr];

  // NOTE: the array has no reset on purpose; the program image must survive rst.
  always_ff @(posedge clk) begin
    if (mem_bus.we) begin
      ram[mem_bus.addr] <= mem_bus.wdata;
    end
  end

endmodule

// File: rtl/risc_cpu.sv
// Top level of the 8-bit accumulator CPU: phase controller, PC/IR/AC datapath
// and the unified memory. Each instruction runs a fixed 8-phase cycle.
module risc_cpu
  import risc_pkg::*;
#(
  parameter int AWIDTH = 5,
  parameter int DWIDTH = 8
) (
  input  logic clk,
  input  logic rst,
  output logic halt
);

  risc_cpu_if #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) mem_bus ();

  risc_memory #(.AWIDTH(AWIDTH), .DWIDTH(DWIDTH)) memory_inst (
    .clk     (clk),
    .mem_bus (mem_bus.slave)
  );

  phase_e            phase_q, phase_d;
  logic [AWIDTH-1:0] pc_q, pc_d;
  logic [DWIDTH-1:0] ir_q, ir_d;
  logic [DWIDTH-1:0] ac_q, ac_d;

  logic [2:0]        opcode;
  logic [AWIDTH-1:0] ir_addr;
  logic              zero;
  logic              mem_we;

  assign opcode  = ir_q[DWIDTH-1 -: 3];
  assign ir_addr = ir_q[AWIDTH-1:0];
  assign zero    = (ac_q == '0);
  assign halt    = (phase_q == PHASE_OP_ADDR) && (opcode == OP_HLT);

  // Fetch half of the cycle addresses the PC, execute half the IR operand.
  assign mem_bus.addr  = phase_q[2] ? ir_addr : pc_q;
  assign mem_bus.wdata = ac_q;
  assign mem_bus.we    = mem_we;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values; the next-state logic below is purely combinational.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q <= PHASE_INST_ADDR;
      pc_q    <= '0;
      ir_q    <= '0;
      ac_q    <= '0;
    end else begin
      phase_q <= phase_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      ac_q    <= ac_d;
    end
  end

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // through the case statement can infer a latch.
    phase_d = halt ? phase_q : phase_e'(phase_q + 3'd1);
    pc_d    = pc_q;
    ir_d    = ir_q;
    ac_d    = ac_q;
    mem_we  = 1'b0;

    unique case (phase_q)
      PHASE_INST_LOAD,
      PHASE_IDLE:     ir_d = mem_bus.rdata;
      PHASE_OP_ADDR:  if (!halt) pc_d = pc_q + AWIDTH'(1);
      PHASE_ALU_OP:   if (opcode == OP_SKZ && zero) pc_d = pc_q + AWIDTH'(1);
      PHASE_STORE: begin
        unique case (opcode)
          OP_ADD:  ac_d = ac_q + mem_bus.rdata;
          OP_AND:  ac_d = ac_q & mem_bus.rdata;
          OP_XOR:  ac_d = ac_q ^ mem_bus.rdata;
          OP_LDA:  ac_d = mem_bus.rdata;
          OP_STO:  mem_we = 1'b1;
          OP_JMP:  pc_d = ir_addr;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_risc_cpu.sv
// Self-checking bench for risc_cpu: directed programs with known halt edges,
// async reset checks, and random programs against an instruction-level model.
module tb_risc_cpu;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic halt;

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0] init_mem [32];
  logic [7:0] exp_mem  [32];

  risc_cpu #(.AWIDTH(5), .DWIDTH(8)) dut (
    .clk  (clk),
    .rst  (rst),
    .halt (halt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] ins(input logic [2:0] op, input logic [4:0] a);
    return {op, a};
  endfunction

  // Instruction-level reference: returns how many non-HLT instructions run
  // before a HLT is fetched, or -1 if none within max_instr. Updates exp_mem.
  function automatic int model_run(input int max_instr);
    int pc = 0;
    int ac = 0;
    for (int k = 0; k < max_instr; k++) begin
      int op = int'(exp_mem[pc][7:5]);
      int a  = int'(exp_mem[pc][4:0]);
      if (op == 0) return k;
      pc = (pc + 1) % 32;
      case (op)
        1: if (ac == 0) pc = (pc + 1) % 32;
        2: ac = (ac + int'(exp_mem[a])) % 256;
        3: ac = ac & int'(exp_mem[a]);
        4: ac = ac ^ int'(exp_mem[a]);
        5: ac = int'(exp_mem[a]);
        6: exp_mem[a] = 8'(ac);
        default: pc = a;
      endcase
    end
    return -1;
  endfunction

  task automatic clear_image();
    for (int i = 0; i < 32; i++) init_mem[i] = 8'h00;
  endtask

  task automatic load_and_reset(input string tag);
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 32; i++) dut.memory_inst.ram[i] = init_mem[i];
    @(posedge clk);
    #1 check($sformatf("%s_reset_halt", tag), 32'(halt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_check(input string tag, input int halt_edge, input int n_edges);
    for (int e = 1; e <= n_edges; e++) begin
      @(posedge clk);
      #1 check($sformatf("%s_edge%0d", tag, e), 32'(halt),
               32'((halt_edge > 0) && (e >= halt_edge)));
    end
  endtask

  task automatic check_mem(input string tag);
    for (int i = 0; i < 32; i++)
      check($sformatf("%s_ram%0d", tag, i), 32'(dut.memory_inst.ram[i]), 32'(exp_mem[i]));
  endtask

  task automatic xor_program();
    clear_image();
    init_mem[0] = ins(3'd5, 5'd10);
    init_mem[1] = ins(3'd4, 5'd11);
    init_mem[2] = ins(3'd1, 5'd0);
    init_mem[3] = ins(3'd7, 5'd5);
    init_mem[4] = ins(3'd0, 5'd0);
    init_mem[5] = ins(3'd4, 5'd12);
    init_mem[6] = ins(3'd1, 5'd0);
    init_mem[7] = ins(3'd0, 5'd0);
    init_mem[8] = ins(3'd7, 5'd9);
    init_mem[9] = ins(3'd0, 5'd0);
    init_mem[10] = 8'h55;
    init_mem[11] = 8'h54;
    init_mem[12] = 8'h01;
  endtask

  initial begin
    // Reset sequence: HLT at address 0 raises halt on the 4th edge.
    clear_image();
    load_and_reset("hlt0");
    run_check("hlt0", 4, 8);

    // Async reset drops halt without waiting for a clock edge.
    #2 rst = 1'b1;
    #1 check("async_rst_halt", 32'(halt), 32'd0);

    // XOR/SKZ program.
    xor_program();
    load_and_reset("xor");
    run_check("xor", 60, 62);

    // Reset mid-instruction aborts and restarts fetch from address 0.
    load_and_reset("abort");
    run_check("abort_pre", 0, 13);
    #3 rst = 1'b1;
    #1 check("abort_rst_halt", 32'(halt), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_check("abort_rerun", 60, 61);

    // AND program, same shape.
    xor_program();
    for (int i = 1; i < 6; i += 4) init_mem[i] = ins(3'd3, init_mem[i][4:0]);
    init_mem[10] = 8'hFF;
    init_mem[11] = 8'h01;
    init_mem[12] = 8'hFE;
    load_and_reset("and");
    run_check("and", 60, 62);

    // ADD wrap to zero, SKZ skip, then no skip.
    clear_image();
    init_mem[0]  = ins(3'd5, 5'd9);
    init_mem[1]  = ins(3'd2, 5'd11);
    init_mem[2]  = ins(3'd1, 5'd0);
    init_mem[3]  = ins(3'd0, 5'd0);
    init_mem[4]  = ins(3'd2, 5'd11);
    init_mem[5]  = ins(3'd1, 5'd0);
    init_mem[6]  = ins(3'd0, 5'd0);
    init_mem[9]  = 8'hFF;
    init_mem[11] = 8'h01;
    load_and_reset("add");
    run_check("add", 44, 46);

    // JMP over a HLT.
    clear_image();
    init_mem[0] = ins(3'd7, 5'd2);
    load_and_reset("jmp");
    run_check("jmp", 12, 14);

    // STO then reload.
    clear_image();
    init_mem[0] = ins(3'd5, 5'd7);
    init_mem[1] = ins(3'd6, 5'd8);
    init_mem[2] = ins(3'd5, 5'd8);
    init_mem[3] = ins(3'd1, 5'd0);
    init_mem[5] = ins(3'd5, 5'd7);
    init_mem[7] = 8'h01;
    load_and_reset("sto");
    run_check("sto", 36, 38);
    check("sto_ram8", 32'(dut.memory_inst.ram[8]), 32'h01);

    // Random programs against the instruction-level model.
    for (int t = 0; t < 24; t++) begin
      int k;
      for (int i = 0; i < 32; i++) begin
        init_mem[i] = 8'($urandom);
        exp_mem[i]  = init_mem[i];
      end
      k = model_run(40);
      load_and_reset($sformatf("rnd%0d", t));
      if (k >= 0) run_check($sformatf("rnd%0d", t), 8 * k + 4, 8 * k + 7);
      else        run_check($sformatf("rnd%0d", t), 0, 320);
      check_mem($sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
